// File: rtl/avalon_5401_pkg.sv
// Shared types and constants for the 5401 pin-bus responder.
// Bus cycle encoding on cpu_bus[7:6], address FSM states, address width and default mailbox address.
package avalon_5401_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam logic [ADDR_W-1:0] MBOX_ADDR_DEF = 12'hFFF;

  typedef enum logic [1:0] {
    BT_IDLE = 2'b00,
    BT_ALO  = 2'b01,
    BT_AHI  = 2'b10,
    BT_WR   = 2'b11
  } bus_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LO   = 2'b01,
    S_RD   = 2'b10
  } state_e;

endpackage

// File: rtl/avalon_5401_mbox.sv
// One-entry nibble mailbox. A push is taken when empty or when popped in the same cycle;
// a pop of an empty mailbox is ignored. accept reports whether this cycle's push was taken.
module avalon_5401_mbox (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [3:0] push_data,
  input  logic       pop,
  output logic       accept,
  output logic       valid,
  output logic [3:0] data
);

  assign accept = push && (!valid || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= 4'h0;
    end else if (accept) begin
      valid <= 1'b1;
      data  <= push_data;
    end else if (pop && valid) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/avalon_5401_bus_responder.sv
// Board-side responder for the 5401 pin bus: nibble RAM emulation plus host<->CPU mailbox on EF0/EF1.
// Mailbox logic is built only when AVALON_RESP_MAILBOX_EN is defined; otherwise its outputs are tied low.
module avalon_5401_bus_responder
  import avalon_5401_pkg::*;
#(
  parameter int unsigned       MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] MBOX_ADDR = MBOX_ADDR_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] cpu_bus,
  output logic [3:0] data_in,
  output logic       EF0,
  output logic       EF1,
  input  logic       host_wr_en,
  input  logic [7:0] host_wr_addr,
  input  logic [3:0] host_wr_data,
  input  logic       h2c_valid,
  input  logic [3:0] h2c_data,
  output logic       h2c_ready,
  output logic       c2h_valid,
  output logic [3:0] c2h_data,
  input  logic       c2h_ready,
  output logic       c2h_ovf
);

  localparam int unsigned MW = $clog2(MEM_DEPTH);
`ifdef AVALON_RESP_MAILBOX_EN
  localparam bit MB_EN = 1'b1;
`else
  localparam bit MB_EN = 1'b0;
`endif

  logic [3:0]        mem [MEM_DEPTH];
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] rd_addr;
  bus_type_e         bus_type;
  logic [5:0]        payload;
  state_e            state_q, state_d;
  logic              rd_fire, wr_fire;
  logic              rd_mbox, wr_mbox, rd_mapped, wr_mapped, host_mapped;
  logic              h2c_full;
  logic [3:0]        h2c_nibble;

  assign bus_type = bus_type_e'(cpu_bus[7:6]);
  assign payload  = cpu_bus[5:0];
  assign rd_addr  = {payload, addr[5:0]};

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // An AHI before any ALO has no low half to pair with, so it is dropped.
  always_comb begin
    state_d = state_q;
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    case (bus_type)
      BT_ALO: state_d = S_LO;
      BT_AHI: begin
        if (state_q != S_IDLE) begin
          state_d = S_RD;
          rd_fire = 1'b1;
        end
      end
      BT_WR:   wr_fire = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr <= '0;
    end else begin
      if (bus_type == BT_ALO) addr[5:0] <= payload;
      if (rd_fire)            addr[ADDR_W-1:6] <= payload;
      if (wr_fire)            addr <= addr + 1'b1;
    end
  end

  assign rd_mbox     = MB_EN && rd_fire && (rd_addr == MBOX_ADDR);
  assign wr_mbox     = MB_EN && wr_fire && (addr == MBOX_ADDR);
  assign rd_mapped   = !rd_mbox && (32'(rd_addr) < MEM_DEPTH);
  assign wr_mapped   = !wr_mbox && (32'(addr) < MEM_DEPTH);
  assign host_mapped = 32'(host_wr_addr) < MEM_DEPTH;

  // Host write is applied last so it wins a same-word collision with the CPU.
  always_ff @(posedge CLK) begin
    if (wr_fire && wr_mapped)     mem[addr[MW-1:0]] <= payload[3:0];
    if (host_wr_en && host_mapped) mem[host_wr_addr[MW-1:0]] <= host_wr_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_in <= 4'h0;
    end else if (rd_fire) begin
      if (rd_mbox)        data_in <= h2c_full ? h2c_nibble : 4'h0;
      else if (rd_mapped) data_in <= mem[rd_addr[MW-1:0]];
      else                data_in <= 4'h0;
    end
  end

`ifdef AVALON_RESP_MAILBOX_EN
  logic c2h_accept;
  logic h2c_accept_unused;

  avalon_5401_mbox u_h2c (
    .clk       (CLK),
    .rst       (RST),
    .push      (h2c_valid && !h2c_full),
    .push_data (h2c_data),
    .pop       (rd_mbox),
    .accept    (h2c_accept_unused),
    .valid     (h2c_full),
    .data      (h2c_nibble)
  );

  avalon_5401_mbox u_c2h (
    .clk       (CLK),
    .rst       (RST),
    .push      (wr_mbox),
    .push_data (payload[3:0]),
    .pop       (c2h_ready),
    .accept    (c2h_accept),
    .valid     (c2h_valid),
    .data      (c2h_data)
  );

  always_ff @(posedge CLK) begin
    if (RST)                         c2h_ovf <= 1'b0;
    else if (wr_mbox && !c2h_accept) c2h_ovf <= 1'b1;
  end

  assign EF0       = h2c_full;
  assign EF1       = c2h_valid;
  assign h2c_ready = !h2c_full;
`else
  logic unused_mbox;
  assign unused_mbox = ^{h2c_valid, h2c_data, c2h_ready, rd_mbox, wr_mbox};
  assign h2c_full    = 1'b0;
  assign h2c_nibble  = 4'h0;
  assign EF0         = 1'b0;
  assign EF1         = 1'b0;
  assign h2c_ready   = 1'b0;
  assign c2h_valid   = 1'b0;
  assign c2h_data    = 4'h0;
  assign c2h_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_5401_bus_responder.sv
// Directed bench for avalon_5401_bus_responder; expectations follow AVALON_RESP_MAILBOX_EN when defined.
module tb_avalon_5401_bus_responder;

`ifdef AVALON_RESP_MAILBOX_EN
  localparam bit MB = 1'b1;
`else
  localparam bit MB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cpu_bus;
  logic [3:0] data_in;
  logic       ef0, ef1;
  logic       host_wr_en;
  logic [7:0] host_wr_addr;
  logic [3:0] host_wr_data;
  logic       h2c_valid;
  logic [3:0] h2c_data;
  logic       h2c_ready;
  logic       c2h_valid;
  logic [3:0] c2h_data;
  logic       c2h_ready;
  logic       c2h_ovf;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  avalon_5401_bus_responder dut (
    .CLK          (clk),
    .RST          (rst),
    .cpu_bus      (cpu_bus),
    .data_in      (data_in),
    .EF0          (ef0),
    .EF1          (ef1),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .h2c_valid    (h2c_valid),
    .h2c_data     (h2c_data),
    .h2c_ready    (h2c_ready),
    .c2h_valid    (c2h_valid),
    .c2h_data     (c2h_data),
    .c2h_ready    (c2h_ready),
    .c2h_ovf      (c2h_ovf)
  );

  function automatic logic [7:0] alo(input logic [5:0] p);
    return {2'b01, p};
  endfunction
  function automatic logic [7:0] ahi(input logic [5:0] p);
    return {2'b10, p};
  endfunction
  function automatic logic [7:0] wr(input logic [3:0] d);
    return {2'b11, 2'b00, d};
  endfunction

  // Drive one bus cycle and return 1 time unit after the sampling edge.
  task automatic cyc(input logic [7:0] b);
    cpu_bus = b;
    @(posedge clk);
    #1;
    cpu_bus = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Read a RAM word through ALO/AHI and check the returned nibble.
  task automatic rd_chk(input string tag, input logic [5:0] lo, input logic [5:0] hi,
                        input logic [3:0] exp);
    cyc(alo(lo));
    cyc(ahi(hi));
    chk(tag, {4'h0, data_in}, {4'h0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_bus = 8'h00;
    host_wr_en = 1'b0; host_wr_addr = 8'h00; host_wr_data = 4'h0;
    h2c_valid = 1'b0; h2c_data = 4'h0; c2h_ready = 1'b0;
    cyc(8'h00);
    cyc(8'h00);
    rst = 1'b0;
    chk("rst_data_in", {4'h0, data_in}, 8'h00);
    chk("rst_ef", {6'h0, ef1, ef0}, 8'h00);
    chk("rst_h2c_ready", {7'h0, h2c_ready}, {7'h0, MB});
    chk("rst_c2h", {2'h0, c2h_ovf, c2h_valid, c2h_data}, 8'h00);

    // Host preload
    host_wr_en = 1'b1; host_wr_addr = 8'h2A; host_wr_data = 4'h7; cyc(8'h00);
    host_wr_addr = 8'h05; host_wr_data = 4'h1; cyc(8'h00);
    host_wr_en = 1'b0;

    rd_chk("read_2a", 6'h2A, 6'h00, 4'h7);
    cyc(8'h00);
    cyc(8'h00);
    chk("hold_idle", {4'h0, data_in}, 8'h07);
    rd_chk("unmapped_100", 6'h00, 6'h04, 4'h0);
    rd_chk("read_05", 6'h05, 6'h00, 4'h1);

    // Same-cycle host and CPU write to 0x005: host nibble stored
    host_wr_en = 1'b1; host_wr_addr = 8'h05; host_wr_data = 4'h3;
    cyc(wr(4'hA));
    host_wr_en = 1'b0;
    rd_chk("collision_host_wins", 6'h05, 6'h00, 4'h3);

    // Burst at 0x005..0x007
    cyc(wr(4'h1)); cyc(wr(4'h2)); cyc(wr(4'h3));
    rd_chk("burst_06", 6'h06, 6'h00, 4'h2);
    rd_chk("burst_07", 6'h07, 6'h00, 4'h3);
    cyc(alo(6'h2A));
    rd_chk("alo_overwrite", 6'h05, 6'h00, 4'h1);

    // Mailbox address; empty h2c reads 0
    rd_chk("mbox_rd_empty", 6'h3F, 6'h3F, 4'h0);
    cyc(wr(4'h5));
    chk("c2h_push_ef1", {7'h0, ef1}, {7'h0, MB});
    chk("c2h_push_data", {4'h0, c2h_data}, MB ? 8'h05 : 8'h00);
    chk("c2h_push_ovf", {7'h0, c2h_ovf}, 8'h00);
    // Address wrapped to 0x000, so this lands in RAM
    cyc(wr(4'h6));
    chk("wrap_no_ovf", {7'h0, c2h_ovf}, 8'h00);
    cyc(alo(6'h3F)); cyc(ahi(6'h3F));
    cyc(wr(4'h6));
    chk("c2h_ovf_set", {7'h0, c2h_ovf}, {7'h0, MB});
    chk("c2h_ovf_data", {4'h0, c2h_data}, MB ? 8'h05 : 8'h00);

    // Full c2h, host pops while CPU pushes
    cyc(alo(6'h3F)); cyc(ahi(6'h3F));
    c2h_ready = 1'b1;
    cyc(wr(4'h9));
    chk("c2h_poppush_data", {4'h0, c2h_data}, MB ? 8'h09 : 8'h00);
    chk("c2h_poppush_ef1", {7'h0, ef1}, {7'h0, MB});
    chk("c2h_poppush_ovf", {7'h0, c2h_ovf}, {7'h0, MB});
    cyc(8'h00);
    c2h_ready = 1'b0;
    chk("c2h_drained", {6'h0, ef1, c2h_valid}, 8'h00);
    rd_chk("wrap_mem_000", 6'h00, 6'h00, 4'h6);

    // Host to CPU mailbox
    h2c_valid = 1'b1; h2c_data = 4'hC;
    cyc(8'h00);
    h2c_valid = 1'b0;
    chk("h2c_push_ef0", {7'h0, ef0}, {7'h0, MB});
    chk("h2c_push_ready", {7'h0, h2c_ready}, 8'h00);
    rd_chk("h2c_read", 6'h3F, 6'h3F, MB ? 4'hC : 4'h0);
    chk("h2c_pop_ef0", {7'h0, ef0}, 8'h00);
    chk("h2c_pop_ready", {7'h0, h2c_ready}, {7'h0, MB});

    // Reset in the middle of an address
    rd_chk("pre_reset_read", 6'h2A, 6'h00, 4'h7);
    cyc(alo(6'h10));
    rst = 1'b1;
    cyc(8'h00);
    rst = 1'b0;
    chk("mid_rst_data_in", {4'h0, data_in}, 8'h00);
    cyc(ahi(6'h01));
    chk("ahi_ignored_data", {4'h0, data_in}, 8'h00);
    chk("ahi_ignored_ef", {6'h0, ef1, ef0}, 8'h00);
    // Address must still be 0x000 after the ignored AHI
    cyc(wr(4'h4));
    rd_chk("ahi_ignored_addr", 6'h00, 6'h00, 4'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
